xdma_w_beat_framer: RTL



---
 rtl/xdma_w_beat_framer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/xdma_w_beat_framer.sv
// xdma_w_beat_framer
// Frames the narrow beat stream coming out of the XDMA write-path width
// converter into AXI4 W-channel bursts. The burst length for each burst is
// taken from a command handshake issued by the AW-side logic. Beats are
// forwarded through a single registered output stage with full strobes and
// WLAST generated on the final beat of each burst.
//
// Ports:
//   clk_i        clock, all state updates on rising edge
//   rst_i        asynchronous active-high reset
//   cmd_len_i    beats in next burst minus one (AxLEN)
//   cmd_valid_i  burst command valid
//   cmd_ready_o  burst command accepted (high only while idle)
//   data_i       input beat from width converter
//   valid_i      input beat valid
//   ready_o      input beat accepted
//   w_data_o     AXI W data (registered)
//   w_strb_o     AXI W strobe, all ones (registered)
//   w_last_o     AXI W last (registered)
//   w_valid_o    AXI W valid (registered)
//   w_ready_i    AXI W ready
//   busy_o       burst in progress or beat held in the output register
module xdma_w_beat_framer #(
  parameter int DW    = 64,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [DW-1:0]    data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [DW-1:0]    w_data_o,
  output logic [DW/8-1:0]  w_strb_o,
  output logic             w_last_o,
  output logic             w_valid_o,
  input  logic             w_ready_i,
  output logic             busy_o
);

  localparam int SW = DW / 8;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;
  logic [SW-1:0]    strb_q, strb_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             cmd_fire_s;
  logic             in_fire_s;
  logic             last_beat_s;

  // Input is accepted only mid-burst, and only when the output slot is free
  // or draining this cycle; this is what gives zero-bubble streaming.
  assign cmd_ready_o = (state_q == S_IDLE);
  assign ready_o     = (state_q == S_STREAM) && (!valid_q || w_ready_i);
  assign cmd_fire_s  = cmd_valid_i && cmd_ready_o;
  assign in_fire_s   = valid_i && ready_o;
  // Counter is LEN_W wide so it meets len_q exactly on the last beat even
  // for the maximum length; the wrap after that beat is harmless.
  assign last_beat_s = (cnt_q == len_q);

  // Burst FSM: command capture in IDLE, beat counting in STREAM.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire_s) begin
          len_d   = cmd_len_i;
          cnt_d   = {LEN_W{1'b0}};
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (in_fire_s) begin
          cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
          if (last_beat_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      default: begin
        state_d = S_IDLE;
        len_d   = {LEN_W{1'b0}};
        cnt_d   = {LEN_W{1'b0}};
      end
    endcase
  end

  // Output stage: fill on input fire (replacing a draining beat), else
  // release the slot once the W handshake completes.
  always_comb begin
    data_d  = data_q;
    strb_d  = strb_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (in_fire_s) begin
      data_d  = data_i;
      strb_d  = {SW{1'b1}};
      last_d  = last_beat_s;
      valid_d = 1'b1;
    end else if (valid_q && w_ready_i) begin
      last_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    busy_d = (state_d == S_STREAM) || valid_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= {LEN_W{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      data_q  <= {DW{1'b0}};
      strb_q  <= {SW{1'b0}};
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign w_data_o  = data_q;
  assign w_strb_o  = strb_q;
  assign w_last_o  = last_q;
  assign w_valid_o = valid_q;
  assign busy_o    = busy_q;

endmodule
